// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants and instruction field helpers
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd7;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int JT_HI  = 25;
    localparam int JT_LO  = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - pipeline register for instruction, pc, pc+1 and valid with hold and flush
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         flush,
    input  logic [N-1:0] instr_in,
    input  logic [N-1:0] pc_in,
    input  logic [N-1:0] pc_plus1_in,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] pc_plus1_out,
    output logic         valid_out
);

    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] pc_plus1_q, pc_plus1_d;
    logic         valid_q, valid_d;

    // Flush beats hold: a redirect must kill the wrong-path entry even while stalled.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d = N'(NOP_INSTR);
            valid_d = 1'b0;
        end else if (!hold) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus1_d = pc_plus1_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= N'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus1_out = pc_plus1_q;
    assign valid_out    = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, next-pc selection and j predecode feeding IF/ID
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] rom_addr,
    input  logic [N-1:0] rom_instr,
    output logic [N-1:0] pc,
    output logic [N-1:0] ifid_instr,
    output logic [N-1:0] ifid_pc,
    output logic [N-1:0] ifid_pc_plus1,
    output logic         ifid_valid,
    output logic [N-1:0] fetch_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [N-1:0]  fetch_count_q, fetch_count_d;
    logic [AW-1:0] pc_plus1;
    logic          is_jump;
    logic [AW-1:0] jump_target;
    logic          unused_bits;

    assign pc_plus1    = pc_q + AW'(1);
    assign is_jump     = (opcode_of(rom_instr[31:0]) == OP_J);
    // Target field shifted left by two, kept to the low AW bits of the word index.
    assign jump_target = {rom_instr[AW-3:0], 2'b00};
    assign unused_bits = ^{redirect_pc[N-1:AW], rom_instr[JT_HI:AW-2]};

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d = redirect_pc[AW-1:0];
        end else if (!stall) begin
            pc_d          = is_jump ? jump_target : pc_plus1;
            fetch_count_d = fetch_count_q + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    ifid_reg #(.N(N)) u_ifid_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (stall),
        .flush        (redirect_valid),
        .instr_in     (rom_instr),
        .pc_in        ({{(N-AW){1'b0}}, pc_q}),
        .pc_plus1_in  ({{(N-AW){1'b0}}, pc_plus1}),
        .instr_out    (ifid_instr),
        .pc_out       (ifid_pc),
        .pc_plus1_out (ifid_pc_plus1),
        .valid_out    (ifid_valid)
    );

    assign rom_addr    = {{(N-AW){1'b0}}, pc_q};
    assign pc          = {{(N-AW){1'b0}}, pc_q};
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized fetch checks against a word-index reference model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    logic [31:0] rom [32];

    int          checks = 0;
    int          errors = 0;

    int          m_pc;
    logic [31:0] m_instr;
    int          m_ifpc;
    int          m_ifpc1;
    bit          m_valid;
    int unsigned m_count;

    instr_fetch_unit #(.N(32), .DEPTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid),
        .fetch_count    (fetch_count)
    );

    assign rom_instr = rom[rom_addr[4:0]];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, 32'(m_pc));
        chk({tag, ".rom_addr"}, rom_addr, 32'(m_pc));
        chk({tag, ".ifid_instr"}, ifid_instr, m_instr);
        chk({tag, ".ifid_pc"}, ifid_pc, 32'(m_ifpc));
        chk({tag, ".ifid_pc_plus1"}, ifid_pc_plus1, 32'(m_ifpc1));
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({tag, ".fetch_count"}, fetch_count, m_count);
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = '0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0; m_count = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] rp);
        logic [31:0] w;
        if (r) begin
            m_pc    = int'(rp % 32);
            m_valid = 0;
            m_instr = '0;
        end else if (!s) begin
            w       = rom[m_pc];
            m_instr = w;
            m_ifpc  = m_pc;
            m_ifpc1 = (m_pc + 1) % 32;
            m_valid = 1;
            m_count = m_count + 1;
            if (w[31:26] == 6'd2) m_pc = (int'(w[25:0]) * 4) % 32;
            else                  m_pc = (m_pc + 1) % 32;
        end
    endtask

    task automatic cycle(input string tag, input bit s, input bit r, input logic [31:0] rp);
        stall = s;
        redirect_valid = r;
        redirect_pc = rp;
        @(posedge clk);
        #1;
        model_step(s, r, rp);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = {6'd7, 26'(i * 7 + 3)};
        rom[0]  = 32'h00221820;
        rom[1]  = 32'h00A63822;
        rom[2]  = 32'h20010005;
        rom[3]  = 32'h8C020000;
        rom[4]  = 32'hAC020004;
        rom[5]  = 32'h08000004;
        rom[16] = 32'h8C010001;
        rom[20] = 32'h08000019;
        rom[31] = 32'h00000000;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        cycle("t1", 0, 0, 0);
        chk("t1.instr_const", ifid_instr, 32'h00221820);
        chk("t1.pc_const", pc, 32'd1);
        cycle("t1b", 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            cycle("t4.stall", 1, 0, 0);
            chk("t4.pc_const", pc, 32'd2);
            chk("t4.instr_const", ifid_instr, 32'h00A63822);
            chk("t4.count_const", fetch_count, 32'd2);
        end
        cycle("t4.release", 0, 0, 0);
        chk("t4.release_pc", pc, 32'd3);

        cycle("t3.redirect", 0, 1, 32'd18);
        chk("t3.pc_const", pc, 32'd18);
        chk("t3.valid_const", {31'b0, ifid_valid}, 32'd0);
        chk("t3.count_const", fetch_count, 32'd3);
        cycle("t3.after", 0, 0, 0);
        chk("t3.ifid_pc_const", ifid_pc, 32'd18);

        cycle("t2.redirect5", 0, 1, 32'd5);
        cycle("t2.jump", 0, 0, 0);
        chk("t2.pc_const", pc, 32'd16);
        chk("t2.j_const", ifid_instr, 32'h08000004);
        cycle("t2.lw", 0, 0, 0);
        chk("t2.lw_const", ifid_instr, 32'h8C010001);
        chk("t2.lw_pc_const", ifid_pc, 32'd16);

        cycle("t5.both", 1, 1, 32'd20);
        chk("t5.pc_const", pc, 32'd20);
        chk("t5.valid_const", {31'b0, ifid_valid}, 32'd0);

        cycle("t6.redirect31", 0, 1, 32'd31);
        cycle("t6.wrap", 0, 0, 0);
        chk("t6.pc_const", pc, 32'd0);
        chk("t6.plus1_const", ifid_pc_plus1, 32'd0);

        for (int i = 0; i < 400; i++) begin
            bit          s;
            bit          r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) == 0);
            rp = $urandom();
            cycle("rand", s, r, rp);
        end

        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #3;
        rst_n = 1'b1;
        cycle("restart", 0, 0, 0);
        chk("restart.instr_const", ifid_instr, 32'h00221820);
        cycle("restart2", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS-subset processor. It is the reader side of the instruction ROM.
- Owns the program counter and drives the ROM word address. It captures the returned instruction into the IF/ID pipeline register.
- J instructions are resolved in fetch with no bubble. Branch and exception redirects arrive from later stages; stalls arrive from the hazard unit.

Parameters:
- N, 32, data/address bus width (matches the ROM).
- DEPTH, 32, ROM depth in words; must be a power of two.
- AW, $clog2(DEPTH), internal PC width (derived; not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  taken branch or other redirect from EX
- redirect_pc  in  N  word-index target; low AW bits used
- rom_addr  out  N  word address to ROM, zero-extended PC
- rom_instr  in  N  combinational ROM data for rom_addr
- pc  out  N  current PC, zero-extended
- ifid_instr  out  N  registered instruction
- ifid_pc  out  N  PC of ifid_instr
- ifid_pc_plus1  out  N  (ifid_pc+1) mod DEPTH
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  N  count of instructions accepted into IF/ID, wraps at 2^N

Behaviour:
- Addressing:
  - PC is a word index; rom_addr = {0, pc}, combinational from the PC register.
  - The ROM returns data in the same cycle, so fetch latency is one clock: the instruction at PC appears on ifid_instr after the next rising edge.
- Reset (async, rst_n=0), independent of clk:
  - pc=0, ifid_instr=0 (NOP), ifid_pc=0, ifid_pc_plus1=0, ifid_valid=0, fetch_count=0.
  - Deasserting reset mid-operation restarts fetch at word 0.
- Predecode, combinational on rom_instr:
  - is_jump = (rom_instr[31:26]==OP_J).
  - jump_target = (rom_instr[25:0]<<2) truncated to AW bits, so field 4 gives word 16.
- Next-PC priority at each rising edge, first match wins:
  1. redirect_valid=1: pc<=redirect_pc[AW-1:0]; ifid_valid<=0; ifid_instr<=0. This flushes the wrong-path instruction. Redirect overrides stall.
  2. stall=1: pc, ifid_* and fetch_count all hold.
  3. is_jump=1: pc<=jump_target. The J itself still enters IF/ID (ifid_valid<=1) so downstream sees it; no bubble.
  4. Otherwise: pc<=(pc+1) mod DEPTH.
- IF/ID capture for cases 3 and 4:
  - ifid_instr<=rom_instr, ifid_pc<=pc, ifid_pc_plus1<=(pc+1) mod DEPTH, ifid_valid<=1.
  - fetch_count increments by 1 in these cases only.
- Wrap-around: pc=DEPTH-1 with no redirect or jump gives next pc=0. Out-of-range redirect or jump targets are masked to AW bits and never fault.
- Unused ROM words read as X/0; the fetch unit treats them as ordinary instructions.
- No combinational path from the stall or redirect inputs to rom_addr. rom_addr depends on the PC register only.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants OP_RTYPE=6'd0, OP_J=6'd2, OP_BEQ=6'd4, OP_ADDI=6'd7, OP_SLTI=6'd10, OP_LW=6'd35, OP_SW=6'd43.
  - NOP_INSTR=32'h0.
  - Opcode field slice bounds [31:26] and J-target field [25:0].
- One natural sub-module: ifid_reg. It holds the N-bit instruction, ifid_pc, ifid_pc_plus1 and valid, with hold (stall) and flush (redirect) controls. It is reused later for ID/EX-style registers.
- Next-PC mux and predecode stay in instr_fetch_unit.

Test Plan:
1. Reset, then release with the standard program loaded (stall=0, redirect_valid=0) -> pc=0 during reset. After 1st edge: pc=1, ifid_instr=32'h00221820, ifid_pc=0, ifid_valid=1, fetch_count=1.
2. Run to word 5 (32'h08000004, J) -> edge after pc=5: pc=16 with no bubble, ifid_instr=32'h08000004. Next edge: ifid_instr=32'h8C010001 (lw), ifid_pc=16.
3. At pc=3, redirect_valid=1 with redirect_pc=18 -> next edge: pc=18, ifid_valid=0, ifid_instr=0, fetch_count unchanged. Following edge: ifid_pc=18, ifid_valid=1.
4. Hold stall=1 for 3 cycles at pc=2 -> pc, ifid_instr (word 1 = 32'h00A63822), ifid_valid and fetch_count constant. Release: pc=3 on the next edge.
5. Assert stall=1 and redirect_valid=1 (redirect_pc=20) together -> redirect wins: pc=20, ifid_valid=0.
6. Redirect to pc=31 (NOP word), then run -> next pc=0 (wrap), ifid_pc_plus1=0. Pulse rst_n low mid-cycle -> all outputs zero immediately, without waiting for an edge.
